// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the bus_fabric address decoder / router.
package bus_fabric_pkg;

  // Access sequencing states of the fabric.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  // Read data returned to the master on any errored access.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Default timeout limit in clk cycles.
  localparam int TMO_CYCLES_DEF = 255;

  // Timeout counter width, wide enough for the largest legal limit.
  localparam int CNT_W = 16;

endpackage

// File: rtl/bus_fabric_dec.sv
// Address decoder: compares the master word address against every slave
// window (base/mask) and returns a one-hot select of the lowest matching slot.
module bus_fabric_dec #(
  parameter int                          NUM_SLV  = 8,
  parameter int                          ADDR_W   = 22,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel
);

  // Per-slot window match, then keep only the lowest index that matched.
  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!hit &&
          ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
           (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit    = 1'b1;
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master to NUM_SLV-slave bus fabric with unmapped-address error
// reporting. Defining BUS_FABRIC_TMO_EN adds an ACTIVE-state timeout that
// turns a silent slave into an errored access after TMO_CYCLES cycles.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                          NUM_SLV    = 8,
  parameter int                          ADDR_W     = 22,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE   = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK   = '0,
  parameter int                          TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_stb,
  input  logic                    bus_we,
  input  logic [ADDR_W-1:0]       bus_addr,
  output logic [31:0]             bus_din,
  output logic                    bus_ack,
  output logic [NUM_SLV-1:0]      slv_stb,
  input  logic [32*NUM_SLV-1:0]   slv_dout,
  input  logic [NUM_SLV-1:0]      slv_ack,
  input  logic                    err_clr,
  output logic                    err_valid,
  output logic [ADDR_W-1:0]       err_addr,
  output logic                    err_we,
  output logic                    err_irq
);

  // Reject illegal configurations at elaboration time.
  if (NUM_SLV < 1 || NUM_SLV > 16 || TMO_CYCLES < 2 || TMO_CYCLES > 65535) begin : g_bad_param
    $error("bus_fabric: NUM_SLV or TMO_CYCLES out of range");
  end

  state_t               state_q, state_d;
  logic [NUM_SLV-1:0]   dec_sel;
  logic                 dec_hit;
  logic [NUM_SLV-1:0]   sel_q;
  logic                 sel_ack;
  logic [31:0]          sel_din;
  logic                 tmo_hit;
  logic                 err_evt;

  bus_fabric_dec #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (bus_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign sel_ack = |(slv_ack & sel_q);

  // Read-data mux for the registered one-hot select.
  always_comb begin
    sel_din = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) sel_din = sel_din | slv_dout[i*32 +: 32];
    end
  end

`ifdef BUS_FABRIC_TMO_EN
  logic [CNT_W-1:0] cnt_q;

  // Cycles spent in ACTIVE without an ack; held at zero in IDLE so every
  // access starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACTIVE && !sel_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ST_ACTIVE) && (cnt_q == CNT_W'(TMO_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and master/slave-facing outputs; an ack in the expiry cycle
  // takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    slv_stb = '0;
    bus_ack = 1'b0;
    bus_din = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_stb) state_d = dec_hit ? ST_ACTIVE : ST_ERR;
      end
      ST_ACTIVE: begin
        slv_stb = sel_q;
        bus_ack = sel_ack;
        bus_din = sel_din;
        if (sel_ack)      state_d = ST_IDLE;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_ERR: begin
        bus_ack = 1'b1;
        bus_din = ERR_RDATA;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // An access cut short by reset is never acknowledged.
    if (rst) bus_ack = 1'b0;
  end

  assign err_evt = (state_d == ST_ERR) && (state_q != ST_ERR);

  // State, slave select and error status registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_we    <= 1'b0;
      err_irq   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus_stb && dec_hit) sel_q <= dec_sel;
      err_irq <= err_evt;
      // First error is kept until cleared; a clear coinciding with a new
      // error lets the new one replace it.
      if (err_evt && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_addr  <= bus_addr;
        err_we    <= bus_we;
      end else if (err_clr && !err_evt) begin
        err_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLV, default 8, number of slave channels (1..16).
REQ-002 SHALL have parameter ADDR_W, default 22, word-address width (bus_addr[23:2]).
REQ-003 SHALL have parameter SLV_BASE, default 0, NUM_SLV*ADDR_W flattened base word addresses; slot i at bits [i*ADDR_W +: ADDR_W].
REQ-004 SHALL have parameter SLV_MASK, default 0, NUM_SLV*ADDR_W flattened compare masks; a 1 bit means that address bit is compared.
REQ-005 SHALL have parameter TMO_CYCLES, default 255, timeout limit in clk cycles (2..65535).
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock; rst  input  1  synchronous active-high reset.
REQ-007 bus_stb  input  1  master strobe, held until bus_ack.
REQ-008 bus_we  input  1  master write enable.
REQ-009 bus_addr  input  ADDR_W  master word address.
REQ-010 bus_din  output  32  read data to master.
REQ-011 bus_ack  output  1  one-cycle acknowledge to master.
REQ-012 slv_stb  output  NUM_SLV  one-hot slave strobes.
REQ-013 slv_dout  input  32*NUM_SLV  flattened slave read data.
REQ-014 slv_ack  input  NUM_SLV  slave acknowledges.
REQ-015 err_clr  input  1  clears the error status.
REQ-016 err_valid  output  1  error status is latched.
REQ-017 err_addr  output  ADDR_W  address of the first unacknowledged error.
REQ-018 err_we  output  1  bus_we of that errored access.
REQ-019 err_irq  output  1  one-cycle pulse per error.

Function
REQ-020 Slave i SHALL match when (bus_addr & MASK_i) == (BASE_i & MASK_i); lowest matching index wins.
REQ-021 FSM states SHALL be IDLE, ACTIVE, ERR.
REQ-022 IDLE with bus_stb=1 and a match SHALL register the one-hot select and go to ACTIVE; with no match, go to ERR.
REQ-023 In ACTIVE, slv_stb SHALL equal the registered select; in IDLE and ERR, slv_stb SHALL be all zero.
REQ-024 In ACTIVE, bus_din and bus_ack SHALL be the selected slave's slv_dout and slv_ack, combinationally; otherwise bus_din=0.
REQ-025 ACTIVE SHALL return to IDLE in the cycle after the selected slv_ack=1; minimum access latency is 2 cycles from bus_stb to bus_ack.
REQ-026 ERR SHALL drive bus_ack=1 and bus_din=32'h00000000 for exactly one cycle, then go to IDLE.
REQ-027 The timeout counter SHALL clear on entering ACTIVE and increment each ACTIVE cycle without ack; reaching TMO_CYCLES SHALL move to ERR.
REQ-028 When slv_ack and timeout expiry coincide, ack SHALL win and no error SHALL be recorded.
REQ-029 On entry to ERR with err_valid=0: set err_valid, latch err_addr/err_we, pulse err_irq; with err_valid=1, pulse err_irq only and keep the first address.
REQ-030 err_clr SHALL clear err_valid next cycle; a simultaneous new error SHALL win and leave err_valid=1 with the new address.
REQ-031 Back-to-back: bus_stb held after ack SHALL start a new decode from IDLE, with one IDLE cycle between accesses.

Reset
REQ-032 rst SHALL force IDLE, slv_stb=0, bus_ack=0, bus_din=0, err_valid=0, err_addr=0, err_we=0, err_irq=0, counter=0.
REQ-033 rst asserted mid-access SHALL drop slv_stb the next cycle; the aborted access SHALL NOT be acknowledged or logged.

Configuration
REQ-034 Macro BUS_FABRIC_TMO_EN defined SHALL include the timeout counter (REQ-027/028); undefined, ACTIVE SHALL wait indefinitely for slv_ack, and unmapped-address errors SHALL still apply.

Structure
REQ-035 Package bus_fabric_pkg SHALL hold the FSM state enum, the error read-data constant 32'h00000000 and the default TMO_CYCLES.
REQ-036 Address matching and priority encoding SHALL live in sub-module bus_fabric_dec; all sequential logic SHALL stay in bus_fabric.

Verification
REQ-037 NUM_SLV=2, slot0 base 0x000000, mask 0x3FF800; slot1 base 0x3FFFF0, mask 0x3FFFFE; read 0x000010, ack after 3 cycles with 0x12345678 -> slv_stb=01, bus_din=0x12345678, bus_ack at cycle 5, err_valid=0.
REQ-038 Read 0x200000 (unmapped) -> no slv_stb, bus_ack at cycle 2 with data 0, err_valid=1, err_addr=0x200000, one err_irq pulse.
REQ-039 TMO_CYCLES=4, slave never acks -> bus_ack forced 5 cycles after ACTIVE entry, err_we reflects the access; without BUS_FABRIC_TMO_EN, no ack ever.
REQ-040 Slave acks in the exact expiry cycle -> normal ack, err_valid stays 0.
REQ-041 Two errors, then err_clr with a third error in the same cycle -> err_valid=1, err_addr=third address; err_clr alone -> err_valid=0.
REQ-042 rst asserted during ACTIVE -> slv_stb=0 next cycle, no bus_ack, err_valid=0.
